// File: rtl/cla_pkg.sv
// Shared carry-lookahead helpers for the CLA adder tree and the pipelined subtractor.
// cla_lookahead resolves up to CLA_MAX positions; unused upper inputs must be tied low.
package cla_pkg;

    localparam int unsigned CLA_MAX = 32;

    typedef struct packed {
        logic carry;
        logic p;
        logic g;
    } cpg_t;

    typedef struct packed {
        logic [CLA_MAX:0] c;
        cpg_t             grp;
    } cla_res_t;

    // c[i] is the carry into position i, c[n] the carry out; grp holds the group-level summary
    function automatic cla_res_t cla_lookahead(
        input int unsigned        n,
        input logic               cin,
        input logic [CLA_MAX-1:0] p,
        input logic [CLA_MAX-1:0] g
    );
        cla_res_t r;
        r           = '0;
        r.c[0]      = cin;
        r.grp.p     = 1'b1;
        r.grp.g     = 1'b0;
        for (int unsigned i = 0; i < CLA_MAX; i++) begin
            if (i < n) begin
                r.c[i+1] = g[i] | (p[i] & r.c[i]);
                r.grp.g  = g[i] | (p[i] & r.grp.g);
                r.grp.p  = r.grp.p & p[i];
            end
        end
        r.grp.carry = r.grp.g | (r.grp.p & cin);
        return r;
    endfunction

endpackage

// File: rtl/cla_group_unit.sv
// Combinational N-wide lookahead block: per-position carries plus group propagate/generate.
module cla_group_unit
    import cla_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         i_c_in,
    input  logic [N-1:0] i_p,
    input  logic [N-1:0] i_g,
    output logic [N-1:0] o_carry,
    output logic         o_c_out,
    output logic         o_pg,
    output logic         o_gg
);

    logic [CLA_MAX-1:0] w_p;
    logic [CLA_MAX-1:0] w_g;
    cla_res_t           w_la;
    logic               w_unused_hi;

    if (N > CLA_MAX) begin : g_n_check
        $error("cla_group_unit: N exceeds CLA_MAX");
    end

    // Zero-extend the operands to the helper's fixed width and evaluate the lookahead
    always_comb begin
        w_p        = '0;
        w_g        = '0;
        w_p[N-1:0] = i_p;
        w_g[N-1:0] = i_g;
        w_la       = cla_lookahead(N, i_c_in, w_p, w_g);
    end

    assign o_carry     = w_la.c[N-1:0];
    assign o_c_out     = w_la.grp.carry;
    assign o_pg        = w_la.grp.p;
    assign o_gg        = w_la.grp.g;
    assign w_unused_hi = ^w_la.c[CLA_MAX:N];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined CLA subtractor: D = A - B - borrow_in computed as A + ~B + ~borrow_in.
// Stage 1 registers group P/G, stage 2 resolves group carries and forms D/borrow/overflow.
module cla_subtractor_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GROUP = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_borrow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_d,
    output logic             out_borrow,
    output logic             out_ovf
);

    localparam int unsigned NG = WIDTH / GROUP;

    if ((WIDTH % GROUP) != 0) begin : g_width_check
        $error("cla_subtractor_pipe: WIDTH must be a multiple of GROUP");
    end

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_nb;
    logic             r_s1_cin;
    logic [NG-1:0]    r_s1_gp;
    logic [NG-1:0]    r_s1_gg;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_d;
    logic             r_out_borrow;
    logic             r_out_ovf;

    logic [WIDTH-1:0] w_in_nb, w_in_p, w_in_g;
    logic [NG-1:0]    w_s1_pg, w_s1_gg;
    logic [WIDTH-1:0] w_s2_p, w_s2_g, w_bit_c, w_d;
    logic [NG-1:0]    w_grp_cin;
    logic             w_carry_out, w_ovf;
    logic             w_s2_can_load, w_s1_can_load, w_accept;

    logic [WIDTH-1:0] w_unused_s1_c;
    logic [NG-1:0]    w_unused_s1_co, w_unused_s2_co, w_unused_s2_pg, w_unused_s2_gg;
    logic             w_unused_top_pg, w_unused_top_gg;

    assign w_in_nb = ~in_b;
    assign w_in_p  = in_a | w_in_nb;
    assign w_in_g  = in_a & w_in_nb;

    for (genvar gi = 0; gi < NG; gi++) begin : g_s1
        cla_group_unit #(.N(GROUP)) u_s1_grp (
            .i_c_in  (1'b0),
            .i_p     (w_in_p[gi*GROUP +: GROUP]),
            .i_g     (w_in_g[gi*GROUP +: GROUP]),
            .o_carry (w_unused_s1_c[gi*GROUP +: GROUP]),
            .o_c_out (w_unused_s1_co[gi]),
            .o_pg    (w_s1_pg[gi]),
            .o_gg    (w_s1_gg[gi])
        );
    end

    // Second-level lookahead: carry into each group straight from cin and group P/G
    cla_group_unit #(.N(NG)) u_top (
        .i_c_in  (r_s1_cin),
        .i_p     (r_s1_gp),
        .i_g     (r_s1_gg),
        .o_carry (w_grp_cin),
        .o_c_out (w_carry_out),
        .o_pg    (w_unused_top_pg),
        .o_gg    (w_unused_top_gg)
    );

    assign w_s2_p = r_s1_a | r_s1_nb;
    assign w_s2_g = r_s1_a & r_s1_nb;

    for (genvar gi = 0; gi < NG; gi++) begin : g_s2
        cla_group_unit #(.N(GROUP)) u_s2_grp (
            .i_c_in  (w_grp_cin[gi]),
            .i_p     (w_s2_p[gi*GROUP +: GROUP]),
            .i_g     (w_s2_g[gi*GROUP +: GROUP]),
            .o_carry (w_bit_c[gi*GROUP +: GROUP]),
            .o_c_out (w_unused_s2_co[gi]),
            .o_pg    (w_unused_s2_pg[gi]),
            .o_gg    (w_unused_s2_gg[gi])
        );
    end

    // nb holds ~b, so "signs of a and b differ" is a == nb at the top bit
    assign w_d   = r_s1_a ^ r_s1_nb ^ w_bit_c;
    assign w_ovf = (r_s1_a[WIDTH-1] == r_s1_nb[WIDTH-1]) && (w_d[WIDTH-1] != r_s1_a[WIDTH-1]);

    assign w_s2_can_load = !r_out_valid || out_ready;
    assign w_s1_can_load = !r_s1_valid || w_s2_can_load;
    assign in_ready      = w_s1_can_load && !reset;
    assign w_accept      = in_valid && in_ready;

    // Stage 1 bank: operands, carry-in and group propagate/generate
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_nb    <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_gp    <= '0;
            r_s1_gg    <= '0;
        end else if (w_s1_can_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a   <= in_a;
                r_s1_nb  <= w_in_nb;
                r_s1_cin <= ~in_borrow;
                r_s1_gp  <= w_s1_pg;
                r_s1_gg  <= w_s1_gg;
            end
        end
    end

    // Stage 2 bank: registered result, held while downstream stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_d      <= '0;
            r_out_borrow <= 1'b0;
            r_out_ovf    <= 1'b0;
        end else if (w_s2_can_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_d      <= w_d;
                r_out_borrow <= ~w_carry_out;
                r_out_ovf    <= w_ovf;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_d      = r_out_d;
    assign out_borrow = r_out_borrow;
    assign out_ovf    = r_out_ovf;

endmodule
